// File: rtl/parking_pkg.sv
// Shared defaults, typedefs and the hour-to-uni-capacity schedule function
// for the parking controller.
package parking_pkg;

   localparam int COUNT_W_DEF     = 10;
   localparam int HOUR_W_DEF      = 5;
   localparam int TOTAL_CAP_DEF   = 700;
   localparam int UNI_CAP_MAX_DEF = 500;
   localparam int DECAY_START_DEF = 13;
   localparam int DECAY_END_DEF   = 16;
   localparam int DECAY_STEP_DEF  = 50;

   typedef logic [COUNT_W_DEF-1:0] count_t;
   typedef logic [HOUR_W_DEF-1:0]  hour_t;

   // Hours 24 and above are folded to midnight.
   function automatic int uni_cap_for_hour(input int h, input int cap_max,
                                           input int d_start, input int d_end,
                                           input int d_step);
      int hh;
      hh = (h >= 24) ? 0 : h;
      if (hh <= d_start)
         return cap_max;
      else if (hh <= d_end)
         return cap_max - d_step * (hh - d_start);
      else
         return cap_max - d_step * (d_end - d_start);
   endfunction

endpackage

// File: rtl/parking_schedule.sv
// Registered hour -> (uni_cap, free_cap) lookup. The registers reset to the
// midnight schedule.
module parking_schedule
   import parking_pkg::*;
#(
   parameter int TOTAL_CAP   = TOTAL_CAP_DEF,
   parameter int UNI_CAP_MAX = UNI_CAP_MAX_DEF,
   parameter int DECAY_START = DECAY_START_DEF,
   parameter int DECAY_END   = DECAY_END_DEF,
   parameter int DECAY_STEP  = DECAY_STEP_DEF,
   parameter int COUNT_W     = COUNT_W_DEF,
   parameter int HOUR_W      = HOUR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [HOUR_W-1:0]  hour,
   output logic [COUNT_W-1:0] uni_cap,
   output logic [COUNT_W-1:0] free_cap
);

   localparam int UNI_RST = uni_cap_for_hour(0, UNI_CAP_MAX, DECAY_START, DECAY_END, DECAY_STEP);

   logic [COUNT_W-1:0] uni_cap_d, uni_cap_q, free_cap_d, free_cap_q;
   int                 cap_int;

   always_comb begin
      cap_int    = uni_cap_for_hour(int'(hour), UNI_CAP_MAX, DECAY_START, DECAY_END, DECAY_STEP);
      uni_cap_d  = COUNT_W'(cap_int);
      free_cap_d = COUNT_W'(TOTAL_CAP - cap_int);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uni_cap_q  <= COUNT_W'(UNI_RST);
         free_cap_q <= COUNT_W'(TOTAL_CAP - UNI_RST);
      end else begin
         uni_cap_q  <= uni_cap_d;
         free_cap_q <= free_cap_d;
      end
   end

   assign uni_cap  = uni_cap_q;
   assign free_cap = free_cap_q;

endmodule

// File: rtl/parking_controller_v2.sv
// Two-zone parking occupancy controller: request edge detection, registered
// grant/reject decisions and zone counters. Optional macro
// PARKING_OVERFLOW_TO_FREE_EN lets uni cars overflow into the free zone.
module parking_controller_v2
   import parking_pkg::*;
#(
   parameter int TOTAL_CAP   = TOTAL_CAP_DEF,
   parameter int UNI_CAP_MAX = UNI_CAP_MAX_DEF,
   parameter int DECAY_START = DECAY_START_DEF,
   parameter int DECAY_END   = DECAY_END_DEF,
   parameter int DECAY_STEP  = DECAY_STEP_DEF,
   parameter int COUNT_W     = COUNT_W_DEF,
   parameter int HOUR_W      = HOUR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [HOUR_W-1:0]  hour,
   input  logic               entry_req,
   input  logic               entry_is_uni,
   input  logic               exit_req,
   input  logic               exit_is_uni,
   output logic               entry_grant,
   output logic               entry_reject,
   output logic               exit_err,
   output logic [COUNT_W-1:0] uni_parked,
   output logic [COUNT_W-1:0] free_parked,
   output logic [COUNT_W-1:0] uni_in_free,
   output logic [COUNT_W-1:0] uni_cap,
   output logic [COUNT_W-1:0] free_cap,
   output logic [COUNT_W-1:0] uni_vacant,
   output logic [COUNT_W-1:0] free_vacant,
   output logic               uni_has_space,
   output logic               free_has_space,
   output logic               lot_has_space
);

   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   logic               entry_req_q, exit_req_q, entry_ev, exit_ev;
   logic               grant_d, grant_q, reject_d, reject_q, err_d, err_q;
   logic [COUNT_W-1:0] uni_d, uni_q, free_d, free_q;
`ifdef PARKING_OVERFLOW_TO_FREE_EN
   logic [COUNT_W-1:0] uif_d, uif_q;
`endif

   parking_schedule #(
      .TOTAL_CAP  (TOTAL_CAP),
      .UNI_CAP_MAX(UNI_CAP_MAX),
      .DECAY_START(DECAY_START),
      .DECAY_END  (DECAY_END),
      .DECAY_STEP (DECAY_STEP),
      .COUNT_W    (COUNT_W),
      .HOUR_W     (HOUR_W)
   ) u_schedule (
      .clk     (clk),
      .rst_n   (rst_n),
      .hour    (hour),
      .uni_cap (uni_cap),
      .free_cap(free_cap)
   );

   assign entry_ev = entry_req & ~entry_req_q;
   assign exit_ev  = exit_req & ~exit_req_q;

   // Entry and exit both judge against pre-update counts; deltas accumulate.
   always_comb begin
      uni_d    = uni_q;
      free_d   = free_q;
`ifdef PARKING_OVERFLOW_TO_FREE_EN
      uif_d    = uif_q;
`endif
      grant_d  = 1'b0;
      reject_d = 1'b0;
      err_d    = 1'b0;
      if (entry_ev) begin
         if (entry_is_uni) begin
            if (uni_q < uni_cap) begin
               uni_d   = uni_d + ONE;
               grant_d = 1'b1;
            end
`ifdef PARKING_OVERFLOW_TO_FREE_EN
            else if (free_q < free_cap) begin
               free_d  = free_d + ONE;
               uif_d   = uif_d + ONE;
               grant_d = 1'b1;
            end
`endif
            else
               reject_d = 1'b1;
         end else if (free_q < free_cap) begin
            free_d  = free_d + ONE;
            grant_d = 1'b1;
         end else
            reject_d = 1'b1;
      end
      if (exit_ev) begin
         if (exit_is_uni) begin
`ifdef PARKING_OVERFLOW_TO_FREE_EN
            if (uif_q != '0) begin
               uif_d  = uif_d - ONE;
               free_d = free_d - ONE;
            end else
`endif
            if (uni_q != '0)
               uni_d = uni_d - ONE;
            else
               err_d = 1'b1;
         end else if (free_q > uni_in_free)
            free_d = free_d - ONE;
         else
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_req_q <= 1'b0;
         exit_req_q  <= 1'b0;
         grant_q     <= 1'b0;
         reject_q    <= 1'b0;
         err_q       <= 1'b0;
         uni_q       <= '0;
         free_q      <= '0;
`ifdef PARKING_OVERFLOW_TO_FREE_EN
         uif_q       <= '0;
`endif
      end else begin
         entry_req_q <= entry_req;
         exit_req_q  <= exit_req;
         grant_q     <= grant_d;
         reject_q    <= reject_d;
         err_q       <= err_d;
         uni_q       <= uni_d;
         free_q      <= free_d;
`ifdef PARKING_OVERFLOW_TO_FREE_EN
         uif_q       <= uif_d;
`endif
      end
   end

`ifdef PARKING_OVERFLOW_TO_FREE_EN
   assign uni_in_free = uif_q;
`else
   assign uni_in_free = '0;
`endif

   assign entry_grant    = grant_q;
   assign entry_reject   = reject_q;
   assign exit_err       = err_q;
   assign uni_parked     = uni_q;
   assign free_parked    = free_q;
   assign uni_vacant     = (uni_cap > uni_q) ? uni_cap - uni_q : '0;
   assign free_vacant    = (free_cap > free_q) ? free_cap - free_q : '0;
   assign uni_has_space  = (uni_vacant != '0);
   assign free_has_space = (free_vacant != '0);
   assign lot_has_space  = uni_has_space | free_has_space;

endmodule
